// File: rtl/mvu_pkg.sv
// Shared MVU types: weight-loader FSM state encoding.
package mvu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } wload_state_t;

endpackage

// File: rtl/mvu_wrap_counter.sv
// Modulo-(MAX+1) counter with synchronous clear; wrap flags the increment
// that returns the count to zero, so instances can be chained.
module mvu_wrap_counter #(
    parameter int unsigned MAX = 1,
    parameter int unsigned W   = (MAX > 0) ? $clog2(MAX + 1) : 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         wrap
);

    logic [W-1:0] count_r;
    logic         at_max_s;

    assign at_max_s = (count_r == W'(MAX));
    assign wrap     = inc & at_max_s;
    assign count    = count_r;

    // count register: clear wins over increment
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (inc) begin
            if (at_max_s) begin
                count_r <= '0;
            end else begin
                count_r <= count_r + W'(1);
            end
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/mvu_weight_mem_loader.sv
// Streams SIMD-wide weight words into per-PE weight memories, address-major
// and PE-minor, with a one-cycle registered write port and done pulse.
module mvu_weight_mem_loader
    import mvu_pkg::*;
#(
    parameter int unsigned SIMD         = 2,
    parameter int unsigned PE           = 2,
    parameter int unsigned TW           = 1,
    parameter int unsigned WMEM_DEPTH   = 4,
    parameter int unsigned WMEM_ADDR_BW = (WMEM_DEPTH > 1) ? $clog2(WMEM_DEPTH) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    load_start,
    input  logic [SIMD*TW-1:0]      s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic [PE-1:0]           wmem_we,
    output logic [WMEM_ADDR_BW-1:0] wmem_waddr,
    output logic [SIMD*TW-1:0]      wmem_wdata,
    output logic                    busy,
    output logic                    load_done
);

    localparam int unsigned PE_CNT_W = (PE > 1) ? $clog2(PE) : 1;

    wload_state_t             state_r;
    wload_state_t             next_state_s;
    logic                     s_ready_r;
    logic                     busy_r;
    logic                     load_done_r;
    logic [PE-1:0]            we_r;
    logic [WMEM_ADDR_BW-1:0]  waddr_r;
    logic [SIMD*TW-1:0]       wdata_r;

    logic                     beat_s;
    logic                     clear_s;
    logic                     pe_wrap_s;
    logic                     last_beat_s;
    logic [PE_CNT_W-1:0]      pe_cnt_s;
    logic [WMEM_ADDR_BW-1:0]  addr_cnt_s;
    logic [PE-1:0]            we_dec_s;

    // s_ready_r is high exactly in LOAD, so it doubles as the accept qualifier
    assign beat_s  = s_valid & s_ready_r;
    assign clear_s = (state_r == IDLE) & load_start;

    mvu_wrap_counter #(.MAX(PE - 1), .W(PE_CNT_W)) u_pe_cnt (
        .clock (clock),
        .reset (reset),
        .clear (clear_s),
        .inc   (beat_s),
        .count (pe_cnt_s),
        .wrap  (pe_wrap_s)
    );

    mvu_wrap_counter #(.MAX(WMEM_DEPTH - 1), .W(WMEM_ADDR_BW)) u_addr_cnt (
        .clock (clock),
        .reset (reset),
        .clear (clear_s),
        .inc   (pe_wrap_s),
        .count (addr_cnt_s),
        .wrap  (last_beat_s)
    );

    // next-state logic; load_start only matters in IDLE
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (load_start) begin
                    next_state_s = LOAD;
                end else begin
                    next_state_s = IDLE;
                end
            end
            LOAD: begin
                if (last_beat_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = LOAD;
                end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // one-hot PE strobe decode of the current PE counter
    always_comb begin
        we_dec_s = '0;
        for (int p = 0; p < int'(PE); p++) begin
            we_dec_s[p] = (pe_cnt_s == PE_CNT_W'(p));
        end
    end

    // state register plus registered state decodes
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= IDLE;
            s_ready_r   <= 1'b0;
            busy_r      <= 1'b0;
            load_done_r <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            s_ready_r   <= (next_state_s == LOAD);
            busy_r      <= (next_state_s != IDLE);
            load_done_r <= (next_state_s == DONE);
        end
    end

    // write port register: strobe for one cycle, address/data hold otherwise
    always_ff @(posedge clock) begin
        if (reset) begin
            we_r    <= '0;
            waddr_r <= '0;
            wdata_r <= '0;
        end else if (beat_s) begin
            we_r    <= we_dec_s;
            waddr_r <= addr_cnt_s;
            wdata_r <= s_data;
        end else begin
            we_r    <= '0;
            waddr_r <= waddr_r;
            wdata_r <= wdata_r;
        end
    end

    assign s_ready    = s_ready_r;
    assign busy       = busy_r;
    assign load_done  = load_done_r;
    assign wmem_we    = we_r;
    assign wmem_waddr = waddr_r;
    assign wmem_wdata = wdata_r;

endmodule
